store_merge_buffer: RTL

- Write-combining stage between the CPU store port and the cache line array.
- Accepts byte-masked stores at any byte offset and merges them into one buffered line with a per-byte valid mask.
- Writes the line back to the array, using read-modify-write when the mask is partial.
- Stores that cross a line boundary are split into two line writes; bytes are never dropped.

---
 rtl/store_merge_buffer.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/store_merge_buffer.sv
// store_merge_buffer: write-combining stage between the CPU store port and
// the cache line array. Byte-masked stores are merged into one buffered line
// with a per-byte valid mask. The line is written back whole, and a partial
// line is first completed with a read-modify-write. A store that crosses a
// line boundary parks its upper bytes in a spill register. Those bytes become
// the next buffered line once the current line has been written.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   st_valid      store request valid
//   st_ready      store accepted when st_valid & st_ready (combinational)
//   st_addr       byte address of store byte 0
//   st_wdata      store data, byte i goes to st_addr+i
//   st_wmask      per-byte enables
//   flush         level request to drain the buffer
//   idle          buffer empty and no drain in progress
//   line_read     array read request (FILL)
//   line_write    array write request (WRITE)
//   line_addr     line-aligned array address
//   line_rdata    array read data, qualified by line_resp in FILL
//   line_wdata    merged line write data
//   line_resp     array completion for the current read or write
module store_merge_buffer #(
    parameter int unsigned LINE_BYTES    = 32,
    parameter int unsigned DATA_BYTES    = 4,
    parameter int unsigned DRAIN_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    st_valid,
    output logic                    st_ready,
    input  logic [31:0]             st_addr,
    input  logic [8*DATA_BYTES-1:0] st_wdata,
    input  logic [DATA_BYTES-1:0]   st_wmask,
    input  logic                    flush,
    output logic                    idle,
    output logic                    line_read,
    output logic                    line_write,
    output logic [31:0]             line_addr,
    input  logic [8*LINE_BYTES-1:0] line_rdata,
    output logic [8*LINE_BYTES-1:0] line_wdata,
    input  logic                    line_resp
);
    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned TAG_W  = 32 - OFF_W;
    localparam int unsigned POS_W  = OFF_W + 1;
    localparam int unsigned DB_W   = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int unsigned CNT_W  = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam int unsigned LINE_W = 8 * LINE_BYTES;
    localparam int unsigned WORD_W = 8 * DATA_BYTES;

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FILL, S_WRITE} state_t;

    state_t state, state_n;

    logic [LINE_W-1:0]     buf_data;
    logic [LINE_BYTES-1:0] buf_mask;
    logic [TAG_W-1:0]      buf_tag;
    logic                  spill_valid;
    logic [TAG_W-1:0]      spill_tag;
    logic [WORD_W-1:0]     spill_data;
    logic [DATA_BYTES-1:0] spill_mask;
    logic [CNT_W-1:0]      tmo_cnt;

    logic [OFF_W-1:0]      st_off;
    logic [TAG_W-1:0]      st_tag;
    logic [POS_W-1:0]      pos [DATA_BYTES];
    logic [LINE_W-1:0]     mrg_data;
    logic [LINE_BYTES-1:0] mrg_mask;
    logic [WORD_W-1:0]     sp_data;
    logic [DATA_BYTES-1:0] sp_mask;
    logic                  spill_only;
    logic [LINE_W-1:0]     fill_data;
    logic                  tmo_hit;

    logic do_store, do_drain, drain_full, do_fill, do_done, tmo_clr, tmo_inc;

    // Place each enabled store byte either in the buffered line or in the spill word.
    always_comb begin
        st_off   = st_addr[OFF_W-1:0];
        st_tag   = st_addr[31:OFF_W];
        mrg_data = buf_data;
        mrg_mask = buf_mask;
        sp_data  = '0;
        sp_mask  = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            pos[i] = {1'b0, st_off} + POS_W'(i);
            if (st_wmask[i]) begin
                if (pos[i][OFF_W]) begin
                    sp_data[8*pos[i][DB_W-1:0] +: 8] = st_wdata[8*i +: 8];
                    sp_mask[pos[i][DB_W-1:0]]        = 1'b1;
                end else begin
                    mrg_data[8*pos[i][OFF_W-1:0] +: 8] = st_wdata[8*i +: 8];
                    mrg_mask[pos[i][OFF_W-1:0]]        = 1'b1;
                end
            end
        end
    end

    // An IDLE store whose bytes all land in the next line goes straight into the buffer.
    assign spill_only = (state == S_IDLE) && (mrg_mask == '0) && (sp_mask != '0);

    // Read-modify-write merge: buffered bytes win over array bytes.
    always_comb begin
        fill_data = '0;
        for (int j = 0; j < LINE_BYTES; j++) begin
            fill_data[8*j +: 8] = buf_mask[j] ? buf_data[8*j +: 8] : line_rdata[8*j +: 8];
        end
    end

    assign tmo_hit = (tmo_cnt == CNT_W'(DRAIN_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, store handshake and datapath strobes.
    always_comb begin
        state_n    = state;
        st_ready   = 1'b0;
        do_store   = 1'b0;
        do_drain   = 1'b0;
        drain_full = 1'b0;
        do_fill    = 1'b0;
        do_done    = 1'b0;
        tmo_clr    = 1'b0;
        tmo_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                st_ready = 1'b1;
                if (st_valid) begin
                    do_store = 1'b1;
                    tmo_clr  = 1'b1;
                    if ((mrg_mask != '0) || (sp_mask != '0)) begin
                        state_n = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                st_ready = (st_tag == buf_tag) && !spill_valid && !flush;
                if (st_valid && st_ready) begin
                    do_store = 1'b1;
                    tmo_clr  = 1'b1;
                end else if (flush || st_valid || spill_valid || tmo_hit) begin
                    // Any unaccepted st_valid here is a tag mismatch.
                    do_drain   = 1'b1;
                    drain_full = &buf_mask;
                    state_n    = drain_full ? S_WRITE : S_FILL;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            S_FILL: begin
                if (line_resp) begin
                    do_fill = 1'b1;
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                if (line_resp) begin
                    do_done = 1'b1;
                    if (spill_valid) begin
                        tmo_clr = 1'b1;
                        state_n = S_HOLD;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Buffer, spill register, timeout counter and array address/data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_data    <= '0;
            buf_mask    <= '0;
            buf_tag     <= '0;
            spill_valid <= 1'b0;
            spill_tag   <= '0;
            spill_data  <= '0;
            spill_mask  <= '0;
            tmo_cnt     <= '0;
            line_addr   <= '0;
            line_wdata  <= '0;
        end else begin
            if (tmo_clr) begin
                tmo_cnt <= '0;
            end else if (tmo_inc) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end

            if (do_store) begin
                if (spill_only) begin
                    buf_tag  <= st_tag + TAG_W'(1);
                    buf_data <= LINE_W'(sp_data);
                    buf_mask <= LINE_BYTES'(sp_mask);
                end else begin
                    buf_data <= mrg_data;
                    buf_mask <= mrg_mask;
                    if (buf_mask == '0) begin
                        buf_tag <= st_tag;
                    end
                    if (sp_mask != '0) begin
                        spill_valid <= 1'b1;
                        spill_tag   <= st_tag + TAG_W'(1);
                        spill_data  <= sp_data;
                        spill_mask  <= sp_mask;
                    end
                end
            end

            if (do_drain) begin
                line_addr <= {buf_tag, OFF_W'(0)};
                if (drain_full) begin
                    line_wdata <= buf_data;
                end
            end

            if (do_fill) begin
                line_wdata <= fill_data;
            end

            // Line committed: retire it and promote any pending spill.
            if (do_done) begin
                if (spill_valid) begin
                    buf_tag     <= spill_tag;
                    buf_data    <= LINE_W'(spill_data);
                    buf_mask    <= LINE_BYTES'(spill_mask);
                    spill_valid <= 1'b0;
                end else begin
                    buf_mask <= '0;
                end
            end
        end
    end

    // Moore decodes of the state register; they drop at once on reset.
    assign idle       = (state == S_IDLE);
    assign line_read  = (state == S_FILL);
    assign line_write = (state == S_WRITE);

endmodule
